// File: rtl/gen_mode_decode_stream.sv
// rtl/gen_mode_decode_stream.sv - receive-side decoder for MODE-selected link encodings
// Registered decode with error counting; output buffer is a single register or a DEPTH-entry FIFO.
module gen_mode_decode_stream #(
  parameter int WIDTH    = 8,
  parameter int MODE     = 0,
  parameter int USE_FIFO = 0,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] dec_data;
  logic             dec_err;
  logic             accept;

  assign accept = in_valid & in_ready;

  generate
    if (MODE == 0) begin : g_dec_pass
      assign dec_data = in_data;
      assign dec_err  = 1'b0;
    end else if (MODE == 1) begin : g_dec_inv
      assign dec_data = ~in_data;
      assign dec_err  = 1'b0;
    end else if (MODE == 2) begin : g_dec_shl
      // The encoder shifts left, so a set LSB can never be produced by a valid word.
      assign dec_data = {1'b0, in_data[WIDTH-1:1]};
      assign dec_err  = in_data[0];
    end else begin : g_dec_zero
      assign dec_data = '0;
      assign dec_err  = |in_data;
    end
  endgenerate

  // Counted at accept time so the count does not depend on consumer back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (accept && dec_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  generate
    if (USE_FIFO == 0) begin : g_reg
      logic [WIDTH-1:0] data_q;
      logic             err_q;
      logic             valid_q;

      assign in_ready  = !valid_q | out_ready;
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign out_err   = err_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          err_q   <= 1'b0;
        end else if (accept) begin
          valid_q <= 1'b1;
          data_q  <= dec_data;
          err_q   <= dec_err;
        end else if (out_ready) begin
          valid_q <= 1'b0;
        end
      end
    end else begin : g_fifo
      localparam int AW = $clog2(DEPTH);
      localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

      logic [WIDTH:0]  mem [DEPTH];
      logic [AW-1:0]   wr_ptr;
      logic [AW-1:0]   rd_ptr;
      logic [AW:0]     count;
      logic            full;
      logic            empty;
      logic            pop;

      assign full      = (count == FULL_CNT);
      assign empty     = (count == '0);
      assign pop       = !empty & out_ready;
      assign in_ready  = !full;
      assign out_valid = !empty;
      assign out_data  = mem[rd_ptr][WIDTH-1:0];
      assign out_err   = mem[rd_ptr][WIDTH];

      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
          if (accept) begin
            mem[wr_ptr] <= {dec_err, dec_data};
            wr_ptr      <= wr_ptr + 1'b1;
          end
          if (pop) rd_ptr <= rd_ptr + 1'b1;
          case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_gen_mode_decode_stream.sv
// tb/tb_gen_mode_decode_stream.sv - randomized and directed bench against a queue reference model
module tb_gen_mode_decode_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] iv, ir, ov, orr, oe, ce;
  logic [7:0] id [4];
  logic [7:0] od [4];
  logic [15:0] ec [3];
  logic [1:0] ec3;

  int checks = 0;
  int failures = 0;

  int mode_of  [4] = '{1, 2, 0, 7};
  int fifo_of  [4] = '{0, 0, 1, 1};
  int depth_of [4] = '{1, 1, 4, 2};
  int cmax_of  [4] = '{65535, 65535, 65535, 3};

  logic [8:0] q[$];
  logic [8:0] last_out;
  int         mcnt;

  always #5 clk = ~clk;

  gen_mode_decode_stream #(.WIDTH(8), .MODE(1), .USE_FIFO(0), .DEPTH(4), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .out_err(oe[0]),
    .clr_err(ce[0]), .err_cnt(ec[0]));
  gen_mode_decode_stream #(.WIDTH(8), .MODE(2), .USE_FIFO(0), .DEPTH(4), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .out_err(oe[1]),
    .clr_err(ce[1]), .err_cnt(ec[1]));
  gen_mode_decode_stream #(.WIDTH(8), .MODE(0), .USE_FIFO(1), .DEPTH(4), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .out_err(oe[2]),
    .clr_err(ce[2]), .err_cnt(ec[2]));
  gen_mode_decode_stream #(.WIDTH(8), .MODE(7), .USE_FIFO(1), .DEPTH(2), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
    .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od[3]), .out_err(oe[3]),
    .clr_err(ce[3]), .err_cnt(ec3));

  // {err, data} as the decoder should produce it, from the arithmetic meaning of each encoding.
  function automatic logic [8:0] model_dec(input int mode, input logic [7:0] d);
    int v;
    v = int'(d);
    case (mode)
      0:       return {1'b0, 8'(v)};
      1:       return {1'b0, 8'(255 - v)};
      2:       return {(v % 2) != 0, 8'(v / 2)};
      default: return {v != 0, 8'h00};
    endcase
  endfunction

  function automatic int get_cnt(input int k);
    if (k == 3) return int'(ec3);
    return int'(ec[k]);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    iv = '0; orr = '0; ce = '0;
    for (int i = 0; i < 4; i++) id[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    mcnt = 0;
    last_out = 9'h000;
  endtask

  // One clock of instance k: compare outputs to the model at negedge, then advance the model.
  task automatic cyc(input int k);
    logic xir, xov, a, d;
    logic [8:0] e, dummy;
    @(negedge clk);
    xov = (q.size() != 0);
    xir = (fifo_of[k] != 0) ? (q.size() < depth_of[k]) : (!xov || orr[k]);
    checks++;
    if (ir[k] !== xir) begin
      failures++;
      $display("FAIL in_ready k=%0d got=%b exp=%b", k, ir[k], xir);
    end
    checks++;
    if (ov[k] !== xov) begin
      failures++;
      $display("FAIL out_valid k=%0d got=%b exp=%b", k, ov[k], xov);
    end
    if (xov) begin
      checks++;
      if ({oe[k], od[k]} !== q[0]) begin
        failures++;
        $display("FAIL out_word k=%0d got=%h exp=%h", k, {oe[k], od[k]}, q[0]);
      end
    end else if (fifo_of[k] == 0) begin
      checks++;
      if ({oe[k], od[k]} !== last_out) begin
        failures++;
        $display("FAIL hold_word k=%0d got=%h exp=%h", k, {oe[k], od[k]}, last_out);
      end
    end
    checks++;
    if (get_cnt(k) !== mcnt) begin
      failures++;
      $display("FAIL err_cnt k=%0d got=%0d exp=%0d", k, get_cnt(k), mcnt);
    end
    a = iv[k] && xir;
    d = xov && orr[k];
    e = model_dec(mode_of[k], id[k]);
    @(posedge clk);
    #1;
    if (d) dummy = q.pop_front();
    if (a) begin
      q.push_back(e);
      last_out = e;
    end
    if (ce[k]) mcnt = 0;
    else if (a && e[8] && mcnt < cmax_of[k]) mcnt++;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || get_cnt(k) !== 0 || od[k] !== 8'h00 || oe[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state k=%0d ov=%b ir=%b cnt=%0d od=%h oe=%b exp ov=0 ir=1 cnt=0 od=00 oe=0",
                 k, ov[k], ir[k], get_cnt(k), od[k], oe[k]);
      end
    end
  endtask

  task automatic test_invert();
    do_reset();
    iv[0] = 1'b1; id[0] = 8'hA5; orr[0] = 1'b1;
    cyc(0);
    iv[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h5A || oe[0] !== 1'b0 || ec[0] !== 16'd0) begin
      failures++;
      $display("FAIL invert_a5 ov=%b od=%h oe=%b cnt=%0d exp 1 5a 0 0", ov[0], od[0], oe[0], ec[0]);
    end
    repeat (2) cyc(0);
  endtask

  task automatic test_shift();
    do_reset();
    orr[1] = 1'b1; iv[1] = 1'b1; id[1] = 8'h84;
    cyc(1);
    checks++;
    if (od[1] !== 8'h42 || oe[1] !== 1'b0) begin
      failures++;
      $display("FAIL shift_84 od=%h oe=%b exp 42 0", od[1], oe[1]);
    end
    id[1] = 8'h85;
    cyc(1);
    iv[1] = 1'b0;
    checks++;
    if (od[1] !== 8'h42 || oe[1] !== 1'b1 || ec[1] !== 16'd1) begin
      failures++;
      $display("FAIL shift_85 od=%h oe=%b cnt=%0d exp 42 1 1", od[1], oe[1], ec[1]);
    end
    repeat (2) cyc(1);
  endtask

  task automatic test_fifo_fill();
    do_reset();
    orr[2] = 1'b0; iv[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id[2] = 8'(i);
      cyc(2);
    end
    iv[2] = 1'b0;
    checks++;
    if (ir[2] !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full_ready got=%b exp=0", ir[2]);
    end
    orr[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (od[2] !== 8'(i)) begin
        failures++;
        $display("FAIL fifo_order got=%h exp=%h", od[2], 8'(i));
      end
      cyc(2);
      if (i == 1) begin
        checks++;
        if (ir[2] !== 1'b1) begin
          failures++;
          $display("FAIL fifo_ready_after_pop got=%b exp=1", ir[2]);
        end
      end
    end
    cyc(2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    iv[2] = 1'b1; orr[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id[2] = 8'($urandom);
      checks++;
      if (ir[2] !== 1'b1 || (i > 0 && ov[2] !== 1'b1)) begin
        failures++;
        $display("FAIL stream_rate i=%0d ir=%b ov=%b exp 1 1", i, ir[2], ov[2]);
      end
      cyc(2);
    end
    iv[2] = 1'b0;
    repeat (2) cyc(2);
  endtask

  task automatic test_saturate();
    logic [1:0] sat_exp [4];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    iv[3] = 1'b1; orr[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id[3] = 8'($urandom_range(1, 255));
      cyc(3);
      checks++;
      if (ec3 !== sat_exp[i]) begin
        failures++;
        $display("FAIL saturate i=%0d got=%0d exp=%0d", i, ec3, sat_exp[i]);
      end
    end
    ce[3] = 1'b1; id[3] = 8'h3C;
    cyc(3);
    ce[3] = 1'b0; iv[3] = 1'b0;
    checks++;
    if (ec3 !== 2'd0) begin
      failures++;
      $display("FAIL clr_priority got=%0d exp=0", ec3);
    end
    repeat (3) cyc(3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    iv[3] = 1'b1; orr[3] = 1'b0;
    id[3] = 8'h11; cyc(3);
    id[3] = 8'h22; cyc(3);
    iv[3] = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (ov[3] !== 1'b0 || ec3 !== 2'd0) begin
      failures++;
      $display("FAIL async_reset ov=%b cnt=%0d exp 0 0", ov[3], ec3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete(); mcnt = 0; last_out = 9'h000;
    orr[3] = 1'b1;
    repeat (3) cyc(3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        iv[k]  = ($urandom % 4) != 0;
        id[k]  = ($urandom % 3 == 0) ? 8'h00 : 8'($urandom);
        orr[k] = (i < 150) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
        ce[k]  = ($urandom % 20) == 0;
        cyc(k);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0; orr = '0; ce = '0;
    for (int i = 0; i < 4; i++) id[i] = 8'h00;
    test_reset();
    test_invert();
    test_shift();
    test_fifo_fill();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
